game_scheduler: RTL and testbench

GAME_SCHEDULER -- requirements
Module: game_scheduler

---
 rtl/game_scheduler.sv | 105 ++++++++++
 tb/tb_game_scheduler.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/game_scheduler.sv
// rtl/game_scheduler.sv - frame tick sequencer, game FSM, BCD score and scroll speed ramp
module game_scheduler #(
  parameter int SCORE_FRAMES = 6,
  parameter int SPEED_FRAMES = 600,
  parameter int MIN_SPEED    = 2,
  parameter int MAX_SPEED    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        game_start_pulse,
  input  logic        game_over_pulse,
  output logic [1:0]  game_tick,
  output logic        scroll_tick,
  output logic [3:0]  scroll_speed,
  output logic [15:0] score,
  output logic        running
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  localparam logic [7:0]  SCORE_LAST = 8'(SCORE_FRAMES - 1);
  localparam logic [11:0] SPEED_LAST = 12'(SPEED_FRAMES - 1);
  localparam logic [3:0]  MIN_SPD    = 4'(MIN_SPEED);
  localparam logic [3:0]  MAX_SPD    = 4'(MAX_SPEED);

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic        enter_run;
  logic [7:0]  score_cnt;
  logic [11:0] speed_cnt;

  // Saturating four-digit BCD increment.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (c) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_OVER: if (game_start_pulse) state_next = S_RUN;
      S_RUN:          if (game_over_pulse)  state_next = S_OVER;
      default:        state_next = S_IDLE;
    endcase
  end

  assign enter_run = (state_next == S_RUN) && (state != S_RUN);
  assign running   = (state == S_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      game_tick    <= 2'b00;
      scroll_tick  <= 1'b0;
      score        <= 16'h0000;
      scroll_speed <= MIN_SPD;
      score_cnt    <= 8'd0;
      speed_cnt    <= 12'd0;
    end else begin
      state <= state_next;
      // A frame_start while either tick is pending is dropped, never deferred.
      game_tick   <= {game_tick[0], frame_start && (game_tick == 2'b00)};
      scroll_tick <= game_tick[0] && (state_next == S_RUN);

      if (enter_run) begin
        score        <= 16'h0000;
        scroll_speed <= MIN_SPD;
        score_cnt    <= 8'd0;
        speed_cnt    <= 12'd0;
      end else if (scroll_tick) begin
        if (score_cnt == SCORE_LAST) begin
          score_cnt <= 8'd0;
          score     <= bcd_inc(score);
        end else begin
          score_cnt <= score_cnt + 8'd1;
        end
        if (speed_cnt == SPEED_LAST) begin
          speed_cnt <= 12'd0;
          if (scroll_speed < MAX_SPD) scroll_speed <= scroll_speed + 4'd1;
        end else begin
          speed_cnt <= speed_cnt + 12'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_game_scheduler.sv
// tb/tb_game_scheduler.sv - randomized and directed checks of game_scheduler against a frame-count model
module tb_game_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fs = 1'b0;
  logic gs = 1'b0;
  logic go = 1'b0;

  logic [1:0]  a_tick, b_tick;
  logic        a_scroll, b_scroll;
  logic [3:0]  a_speed, b_speed;
  logic [15:0] a_score, b_score;
  logic        a_running, b_running;

  int checks = 0;
  int passed = 0;
  int fails = 0;

  // Model: cycle index, cycle of last accepted frame_start, game mode, scroll ticks since entry to RUN.
  int cyc = 0;
  int fs_cycle = -10;
  int mode = 0;
  int k = 0;
  logic e_t0 = 1'b0;
  logic e_t1 = 1'b0;
  logic e_sc = 1'b0;

  always #5 clk = ~clk;

  game_scheduler #(.SCORE_FRAMES(1), .SPEED_FRAMES(2), .MIN_SPEED(2), .MAX_SPEED(4)) dut_a (
    .clk(clk), .rst(rst), .frame_start(fs), .game_start_pulse(gs), .game_over_pulse(go),
    .game_tick(a_tick), .scroll_tick(a_scroll), .scroll_speed(a_speed), .score(a_score),
    .running(a_running));

  game_scheduler #(.SCORE_FRAMES(6), .SPEED_FRAMES(4), .MIN_SPEED(3), .MAX_SPEED(5)) dut_b (
    .clk(clk), .rst(rst), .frame_start(fs), .game_start_pulse(gs), .game_over_pulse(go),
    .game_tick(b_tick), .scroll_tick(b_scroll), .scroll_speed(b_speed), .score(b_score),
    .running(b_running));

  function automatic logic [15:0] to_bcd(input int v);
    int x;
    x = (v > 9999) ? 9999 : v;
    return {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
  endfunction

  function automatic logic [15:0] exp_speed(input int ticks, input int mn, input int mx, input int spf);
    int s;
    s = mn + ticks / spf;
    if (s > mx) s = mx;
    return 16'(s);
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    checks++;
    assert (obs === exp_v) passed++;
    else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic step(input logic f, input logic s, input logic o, input logic r);
    fs = f; gs = s; go = o; rst = r;
    @(posedge clk);
    if (r) begin
      mode = 0; k = 0; fs_cycle = -10;
    end else begin
      if (e_sc) k++;
      case (mode)
        0, 2: if (s) begin mode = 1; k = 0; end
        1:    if (o) mode = 2;
        default: mode = 0;
      endcase
      if (f && cyc > fs_cycle + 2) fs_cycle = cyc;
    end
    cyc++;
    e_t0 = (cyc == fs_cycle + 1);
    e_t1 = (cyc == fs_cycle + 2);
    e_sc = e_t1 && (mode == 1);
    #1;
    check("a_game_tick", 16'(a_tick), 16'({e_t1, e_t0}));
    check("b_game_tick", 16'(b_tick), 16'({e_t1, e_t0}));
    check("a_scroll_tick", 16'(a_scroll), 16'(e_sc));
    check("b_scroll_tick", 16'(b_scroll), 16'(e_sc));
    check("a_running", 16'(a_running), 16'(mode == 1));
    check("b_running", 16'(b_running), 16'(mode == 1));
    check("a_score", a_score, to_bcd(k));
    check("b_score", b_score, to_bcd(k / 6));
    check("a_speed", 16'(a_speed), exp_speed(k, 2, 4, 2));
    check("b_speed", 16'(b_speed), exp_speed(k, 3, 5, 4));
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      idle(2);
    end
  endtask

  initial begin
    // Reset, including reset dominating every other input.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(5);

    // Idle-state tick pair, no scroll.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Back-to-back frame_start: the second is dropped.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);

    // Reset at N+1 aborts the sequence.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);

    // game_over ignored in IDLE, then start and run 12 frames.
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    frames(12);

    // game_start ignored in RUN.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    frames(3);

    // game_over coincident with scroll_tick, then frozen over 5 frames.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    frames(5);

    // Both pulses in OVER restart; both pulses in RUN end the game.
    step(1'b0, 1'b1, 1'b1, 1'b0);
    frames(4);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    idle(2);

    // Random mix of frames, pulses and occasional resets.
    repeat (600)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 49) == 0), ($urandom_range(0, 199) == 0));

    // Long run to BCD rollovers and score saturation.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    while (k < 10010 && cyc < 90000)
      step(($urandom_range(0, 3) != 0), 1'b0, 1'b0, 1'b0);
    check("a_score_saturated", a_score, 16'h9999);
    check("a_speed_saturated", 16'(a_speed), 16'd4);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
